// File: rtl/sq_block_pkg.sv
// Shared definitions for the SqueezeNext block sequencer: per-conv descriptor
// tables, read-source encodings and the controller state enum.
package sq_block_pkg;

  localparam int N_CONV = 6;
  localparam int CONV_W = $clog2(N_CONV);

  typedef enum logic [1:0] {
    SRC_TRANS = 2'd0,
    SRC_PING  = 2'd1,
    SRC_PONG  = 2'd2,
    SRC_SKIP  = 2'd3
  } rd_src_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Per-conv descriptors: pixels, passes (bias groups), source/destination
  // buffers, pad-column substitution and whether the result is also kept
  // in the skip BRAM for the residual path.
  localparam int unsigned PIX  [N_CONV] = '{4, 8, 8, 8, 6, 4};
  localparam int unsigned PASS [N_CONV] = '{2, 1, 1, 2, 2, 4};
  localparam rd_src_e     SRC  [N_CONV] = '{SRC_TRANS, SRC_PING, SRC_PONG,
                                            SRC_PING,  SRC_PONG, SRC_PING};
  localparam rd_src_e     DST  [N_CONV] = '{SRC_PING, SRC_PONG, SRC_PING,
                                            SRC_PONG, SRC_PING, SRC_PONG};
  localparam bit          PAD       [N_CONV] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit          SAVE_SKIP [N_CONV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/sq_delay_line.sv
// Stall-aware shift register that carries read-side context to the write
// side of the adder tree; it advances only when en is high.
module sq_delay_line #(
  parameter int W   = 8,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[LAT-1];

endmodule

// File: rtl/sq_block_seq.sv
// Sequencer for one SqueezeNext block: walks N_CONV convolutions, issuing read
// addresses and MAC-tree strobes. Optional pad-column detection: SQB_PADDING_EN.
module sq_block_seq
  import sq_block_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int WADDR_W = 4,
  parameter int PASS_W  = 2,
  parameter int MAC_LAT = 3,
  parameter int IMG_W   = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic [CONV_W-1:0]  u,
  output logic [CONV_W-1:0]  u_wr,
  output logic [PASS_W-1:0]  z,
  output logic [WADDR_W-1:0] weight_addr,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [1:0]         rd_src,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [2:0]         wr_en,
  output logic               load,
  output logic               acc_clear,
  output logic               padding,
  output state_t             dbg_state
);

  localparam int DCNT_W = $clog2(MAC_LAT + 1);
  localparam int DL_W   = 1 + CONV_W + ADDR_W;

  // Handshake: start is sampled only in IDLE (stall does not block it);
  // busy stays high from the accepted start through the single-cycle done
  // pulse. stall freezes every counter and the delay line and masks the
  // strobes for that cycle; the DONE state always retires so done never
  // stretches.
  state_t             state;
  logic [DCNT_W-1:0]  drain_cnt;
  logic [ADDR_W-1:0]  pix_last;
  logic [PASS_W-1:0]  pass_last;
  logic               issue_last;
  logic [DL_W-1:0]    dl_d;
  logic [DL_W-1:0]    dl_q;
  logic               dl_last;
  logic [2:0]         wr_sel;

  always_comb begin
    pix_last  = ADDR_W'(PIX[u] - 1);
    pass_last = PASS_W'(PASS[u] - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      u         <= '0;
      z         <= '0;
      rd_addr   <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            u       <= '0;
            z       <= '0;
            rd_addr <= '0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (z == pass_last) begin
              z <= '0;
              if (rd_addr == pix_last) begin
                state     <= S_DRAIN;
                drain_cnt <= '0;
              end else begin
                rd_addr <= rd_addr + 1'b1;
              end
            end else begin
              z <= z + 1'b1;
            end
          end
        end
        // Wait out the adder-tree latency so the last write of this conv
        // lands before the next conv reads its ping/pong buffer.
        S_DRAIN: begin
          if (!stall) begin
            if (drain_cnt == DCNT_W'(MAC_LAT - 1)) begin
              rd_addr <= '0;
              if (u == CONV_W'(N_CONV - 1)) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_NEXT;
                u     <= u + 1'b1;
              end
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        S_NEXT: begin
          if (!stall) state <= S_RUN;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          u     <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state   = state;
  assign weight_addr = WADDR_W'(z);
  assign rd_src      = SRC[u];
  assign acc_clear   = (state == S_RUN) && (z == '0) && !stall;
  assign issue_last  = (state == S_RUN) && (z == pass_last);

  assign dl_d = {issue_last, u, rd_addr};

  sq_delay_line #(
    .W   (DL_W),
    .LAT (MAC_LAT)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!stall),
    .d     (dl_d),
    .q     (dl_q)
  );

  assign {dl_last, u_wr, wr_addr} = dl_q;
  assign load = dl_last && !stall;

  always_comb begin
    wr_sel = '0;
    case (DST[u_wr])
      SRC_PING: wr_sel[0] = 1'b1;
      SRC_PONG: wr_sel[1] = 1'b1;
      SRC_SKIP: wr_sel[2] = 1'b1;
      default:  wr_sel    = '0;
    endcase
    if (SAVE_SKIP[u_wr]) wr_sel[2] = 1'b1;
    wr_en = load ? wr_sel : 3'b000;
  end

`ifdef SQB_PADDING_EN
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [COL_W-1:0] col;
  logic             pix_step;

  // col mirrors rd_addr mod IMG_W; rd_addr is always 0 on RUN entry.
  assign pix_step = (state == S_RUN) && !stall && (z == pass_last) && (rd_addr != pix_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
    end else if (state != S_RUN) begin
      col <= '0;
    end else if (pix_step) begin
      col <= (col == COL_W'(IMG_W - 1)) ? '0 : col + 1'b1;
    end
  end

  assign padding = (state == S_RUN) && PAD[u] && ((col == '0) || (col == COL_W'(IMG_W - 1)));
`else
  assign padding = 1'b0;
`endif

endmodule

// File: tb/tb_sq_block_seq.sv
// Self-checking bench for sq_block_seq: a step-level reference trace built
// from the per-conv descriptors, randomized stall/start noise, and an abort.
module tb_sq_block_seq;
  import sq_block_pkg::*;

  localparam int N    = 6;
  localparam int L    = 3;
  localparam int IMGW = 4;
  localparam int WW   = 16;

  int pix_t  [N] = '{4, 8, 8, 8, 6, 4};
  int pass_t [N] = '{2, 1, 1, 2, 2, 4};
  int src_t  [N] = '{0, 1, 2, 1, 2, 1};
  int dst_t  [N] = '{1, 2, 1, 2, 1, 2};
  int skip_t [N] = '{0, 1, 0, 0, 0, 0};
  int pad_t  [N] = '{1, 0, 0, 1, 0, 0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        busy, done, load, acc_clear, padding;
  logic [2:0]  u, u_wr, wr_en;
  logic [1:0]  z, rd_src;
  logic [3:0]  weight_addr;
  logic [9:0]  rd_addr, wr_addr;
  state_t      dbg_state;

  sq_block_seq #(
    .ADDR_W (10), .WADDR_W (4), .PASS_W (2), .MAC_LAT (L), .IMG_W (IMGW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .stall (stall),
    .busy (busy), .done (done), .u (u), .u_wr (u_wr), .z (z),
    .weight_addr (weight_addr), .rd_addr (rd_addr), .rd_src (rd_src),
    .wr_addr (wr_addr), .wr_en (wr_en), .load (load), .acc_clear (acc_clear),
    .padding (padding), .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit rd;
    bit dn;
    int u;
    int z;
    int pix;
    bit ld;
  } step_t;

  step_t          tr[$];
  logic [WW-1:0]  exp_q[$];
  int             s_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] wr_word(input int c, input int p);
    logic [2:0] en;
    en = 3'(1 << (dst_t[c] - 1));
    if (skip_t[c] != 0) en[2] = 1'b1;
    return {en, 3'(c), 10'(p)};
  endfunction

  function automatic bit pad_exp(input int c, input int p);
`ifdef SQB_PADDING_EN
    return (pad_t[c] != 0) && ((p % IMGW == 0) || (p % IMGW == IMGW - 1));
`else
    return 1'b0;
`endif
  endfunction

  // A write is due L steps after the final pass of each pixel is issued.
  function automatic void push_step(input step_t st_in);
    step_t st;
    int    n;
    st = st_in;
    n  = tr.size();
    if (n >= L && tr[n-L].rd && tr[n-L].z == pass_t[tr[n-L].u] - 1) begin
      st.ld = 1'b1;
      exp_q.push_back(wr_word(tr[n-L].u, tr[n-L].pix));
    end
    tr.push_back(st);
  endfunction

  function automatic void build_trace();
    step_t st;
    tr.delete();
    exp_q.delete();
    s_total = 0;
    for (int c = 0; c < N; c++) begin
      for (int p = 0; p < pix_t[c]; p++) begin
        for (int q = 0; q < pass_t[c]; q++) begin
          st = '{rd: 1'b1, dn: 1'b0, u: c, z: q, pix: p, ld: 1'b0};
          push_step(st);
          s_total++;
        end
      end
      for (int d = 0; d < L; d++) begin
        st = '{rd: 1'b0, dn: 1'b0, u: c, z: 0, pix: pix_t[c] - 1, ld: 1'b0};
        push_step(st);
      end
      if (c == N - 1) st = '{rd: 1'b0, dn: 1'b1, u: c, z: 0, pix: 0, ld: 1'b0};
      else            st = '{rd: 1'b0, dn: 1'b0, u: c + 1, z: 0, pix: 0, ld: 1'b0};
      push_step(st);
    end
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_u"}, u, 0);
    check({tag, "_z"}, z, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_rd_src"}, rd_src, 0);
    check({tag, "_waddr"}, weight_addr, 0);
    check({tag, "_u_wr"}, u_wr, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_load"}, load, 0);
    check({tag, "_acc_clear"}, acc_clear, 0);
    check({tag, "_padding"}, padding, 0);
  endtask

  task automatic abort_seq();
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    #1 check_zero("abort");
    @(negedge clk);
    #1 check_zero("abort_hold");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (L + 3) begin
      @(negedge clk);
      #1;
      check("post_abort_busy", busy, 0);
      check("post_abort_done", done, 0);
      check("post_abort_load", load, 0);
    end
    exp_q.delete();
  endtask

  // mode 0: clean run, 1: one 5-cycle stall inside conv2, 2: random stall and start noise
  task automatic run_block(input int mode, input bit do_abort);
    int            k          = 0;
    int            busy_cnt   = 0;
    int            held       = 0;
    int            dones      = 0;
    int            stall_left = 0;
    bit            stall_used = 1'b0;
    int            last_wr[N];
    int            first_rd[N];
    logic [WW-1:0] e;
    for (int i = 0; i < N; i++) begin
      last_wr[i]  = -1;
      first_rd[i] = -1;
    end
    build_trace();
    @(negedge clk);
    start = 1'b1;
    stall = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1 check("start_idle_busy", busy, 0);
    while (k < tr.size()) begin
      @(negedge clk);
      start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mode == 1 && !stall_used && tr[k].rd && tr[k].u == 2 && tr[k].pix == 3) begin
        stall_left = 5;
        stall_used = 1'b1;
      end
      if (mode == 2) begin
        stall = ($urandom_range(0, 3) == 0);
      end else begin
        stall = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end
      if (do_abort && tr[k].rd && tr[k].u == 3 && tr[k].pix == 2) begin
        abort_seq();
        return;
      end
      #1;
      check("busy", busy, 1);
      check("done", done, tr[k].dn);
      check("u", u, tr[k].u);
      check("z", z, tr[k].z);
      check("rd_addr", rd_addr, tr[k].pix);
      check("rd_in_range", (u < N) && (rd_addr < pix_t[u]), 1);
      if (tr[k].rd) begin
        check("rd_src", rd_src, src_t[tr[k].u]);
        check("weight_addr", weight_addr, tr[k].z);
        check("padding", padding, pad_exp(tr[k].u, tr[k].pix));
        if (first_rd[tr[k].u] < 0) first_rd[tr[k].u] = busy_cnt;
      end else begin
        check("padding_norun", padding, 0);
      end
      check("acc_clear", acc_clear, tr[k].rd && tr[k].z == 0 && !stall);
      check("load", load, tr[k].ld && !stall);
      if (load) begin
        if (exp_q.size() == 0) begin
          check("extra_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("write", {wr_en, u_wr, wr_addr}, e);
          if (u_wr < N) last_wr[u_wr] = busy_cnt;
        end
      end else begin
        check("wr_en_quiet", wr_en, 0);
      end
      if (done) dones++;
      if (!stall || tr[k].dn) k++;
      else held++;
      busy_cnt++;
      if (busy_cnt > 4000) begin
        check("timeout", busy_cnt, 0);
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    #1;
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("busy_len", busy_cnt, s_total + N * (L + 1) + held);
    check("done_count", dones, 1);
    check("writes_left", exp_q.size(), 0);
    for (int c = 0; c < N - 1; c++)
      check("raw_order", (last_wr[c] >= 0) && (last_wr[c] < first_rd[c+1]), 1);
    if (mode == 1) check("stall_cycles", held, 5);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_zero("idle");

    run_block(0, 1'b0);
    run_block(1, 1'b0);
    for (int r = 0; r < 3; r++) run_block(2, 1'b0);
    run_block(0, 1'b1);
    run_block(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
